wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one parameter: NREQ, default 3, number of write-back requesters (index 0 = ALU, 1 = LSU, 2 = MDU).
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- res  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i holds a write-back.
- req_ready  out  NREQ  requester i accepted this cycle.
- req_rd  in  5*NREQ  destination register, slice i.
- req_data  in  32*NREQ  write data, slice i.
- iss_valid  in  1  issue stage claims a destination.
- iss_rd  in  5  claimed destination.
- rs1, rs2  in  5 each  source registers of the instruction in issue.
- stall  out  1  a source operand is pending.
- wr_addr  out  5  register-file write address (A3).
- wr_data  out  32  register-file write data (WD).
- sb_busy  out  32  scoreboard pending vector.

Function
REQ-003 The block SHALL accept at most one requester per cycle; req_ready SHALL be one-hot or zero and is asserted only where req_valid is high.
REQ-004 A transfer SHALL occur when req_valid[i] && req_ready[i]; requesters hold rd/data stable until accepted.
REQ-005 Arbitration SHALL be round-robin: a 2-bit pointer starts at 0 and moves to (granted index + 1) mod NREQ after each transfer; it holds when there is no transfer.
REQ-006 The accepted rd/data SHALL be registered into wr_addr/wr_data, giving 1-cycle latency from acceptance to the register-file write port.
REQ-007 In any cycle with no transfer, wr_addr SHALL be driven to 0 on the next edge. The register file discards writes to x0, so this is the idle encoding.
REQ-008 iss_valid with iss_rd != 0 SHALL set sb_busy[iss_rd] at the next edge; iss_rd = 0 SHALL be ignored.
REQ-009 A transfer with rd != 0 SHALL clear sb_busy[rd] at the next edge.
REQ-010 If a set and a clear target the same rd in the same cycle, the set SHALL win.
REQ-011 stall SHALL be combinational. It is high when rsX != 0 and either sb_busy[rsX] is set or wr_addr == rsX, for X = 1 or 2. This covers the write that is still in the output register.
REQ-012 A transfer with rd = 0 SHALL be accepted normally and produce wr_addr = 0.
REQ-013 sb_busy[0] SHALL always read 0.

Reset
REQ-014 While res = 0, the block SHALL asynchronously force: wr_addr = 0, wr_data = 0, sb_busy = 0, round-robin pointer = 0, req_ready = 0.
REQ-015 A reset asserted mid-operation SHALL drop any accepted write that has not yet reached the register file, and SHALL clear all pending bits.
REQ-016 After res deasserts, the first grant SHALL go to requester 0 if it is valid.

Configuration
REQ-017 Macro WB_RR_EN:
- Defined: round-robin arbitration per REQ-005.
- Undefined: fixed priority, lowest index wins, and the pointer logic is removed.
- All other behaviour SHALL be identical in both builds.

Structure
REQ-018 A shared package SHALL hold:
- REG_ADDR_W = 5, XLEN = 32, NUM_REGS = 32;
- requester index constants REQ_ALU, REQ_LSU, REQ_MDU.
REQ-019 The arbiter SHALL be a sub-module, rr_arbiter (request vector in, one-hot grant out, with its pointer). Scoreboard and output register stay in wb_arbiter.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset then idle: wr_addr = 0, sb_busy = 0, stall = 0 on every cycle.
- iss_rd = 5, then ALU writes rd = 5, data 0xDEAD_BEEF: sb_busy[5] is set → cleared one cycle after acceptance; wr_addr = 5 and wr_data = 0xDEADBEEF one cycle later; stall for rs1 = 5 stays high until that write cycle has passed.
- All three requesters valid for 6 cycles (WB_RR_EN defined): grants run 0,1,2,0,1,2. Without the macro: six grants to 0.
- Same cycle: iss_rd = 7 and LSU write-back of rd = 7: sb_busy[7] stays 1.
- Issue to rd = 0, and ALU write of rd = 0 with data 0x1234: sb_busy stays 0, wr_addr = 0, req_ready[0] = 1.
- res pulsed low while sb_busy = 0x0000_00F0 and a write is in the output register: all outputs are 0 immediately, with no edge needed.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter: register-file geometry and requester indices.
package wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;

   localparam int REQ_ALU = 0;
   localparam int REQ_LSU = 1;
   localparam int REQ_MDU = 2;

   localparam int PTR_W = 2;

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// One-hot grant arbiter for write-back requesters.
// WB_RR_EN defined: round-robin with a 2-bit pointer; undefined: fixed priority, lowest index wins.
module rr_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int NREQ = 3
) (
`ifdef WB_RR_EN
   input  logic            clk,
   input  logic            res,
`endif
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt
);

   logic found;

`ifdef WB_RR_EN
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_nxt;
   int               idx;

   // Search starts at the pointer; the pointer only moves when something is granted.
   always_comb begin
      gnt     = '0;
      found   = 1'b0;
      idx     = 0;
      ptr_nxt = ptr;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            ptr_nxt  = PTR_W'((idx + 1) % NREQ);
         end
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) ptr <= '0;
      else      ptr <= ptr_nxt;
   end
`else
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks one requester per cycle, registers it onto the register-file
// write port and tracks pending destinations in a scoreboard. WB_RR_EN selects round-robin.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic                       clk,
   input  logic                       res,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [REG_ADDR_W*NREQ-1:0] req_rd,
   input  logic [XLEN*NREQ-1:0]       req_data,
   input  logic                       iss_valid,
   input  logic [REG_ADDR_W-1:0]      iss_rd,
   input  logic [REG_ADDR_W-1:0]      rs1,
   input  logic [REG_ADDR_W-1:0]      rs2,
   output logic                       stall,
   output logic [REG_ADDR_W-1:0]      wr_addr,
   output logic [XLEN-1:0]            wr_data,
   output logic [NUM_REGS-1:0]        sb_busy
);

   logic [NREQ-1:0]       gnt;
   logic                  xfer;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;
   logic [NUM_REGS-1:0]   sb_next;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
`ifdef WB_RR_EN
      .clk (clk),
      .res (res),
`endif
      .req (req_valid),
      .gnt (gnt)
   );

   // Gate with reset so ready is low while the block is held in reset.
   assign req_ready = gnt & {NREQ{res}};
   assign xfer      = |req_ready;

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            sel_rd   = sel_rd   | req_rd[i*REG_ADDR_W +: REG_ADDR_W];
            sel_data = sel_data | req_data[i*XLEN +: XLEN];
         end
      end
   end

   // Set is applied after clear so a same-cycle issue to the same rd keeps it pending.
   always_comb begin
      sb_next = sb_busy;
      if (xfer && (sel_rd != '0))        sb_next[sel_rd] = 1'b0;
      if (iss_valid && (iss_rd != '0))   sb_next[iss_rd] = 1'b1;
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wr_addr <= '0;
         wr_data <= '0;
         sb_busy <= '0;
      end else begin
         sb_busy <= sb_next;
         if (xfer) begin
            wr_addr <= sel_rd;
            wr_data <= sel_data;
         end else begin
            wr_addr <= '0;
         end
      end
   end

   // wr_addr compare covers the write still sitting in the output register.
   assign stall = ((rs1 != '0) && (sb_busy[rs1] || (wr_addr == rs1))) ||
                  ((rs2 != '0) && (sb_busy[rs2] || (wr_addr == rs2)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic against a reference model.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        res;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [14:0] req_rd;
   logic [95:0] req_data;
   logic        iss_valid;
   logic [4:0]  iss_rd, rs1, rs2;
   logic        stall;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] sb_busy;

   int vectors = 0;
   int miscompares = 0;

   bit   [31:0] mbusy;
   int          mptr;
   logic [4:0]  mwa;
   logic [31:0] mwd;
   int          mgnt;
   logic [2:0]  obs_rdy;

   wb_arbiter #(.NREQ(3)) dut (
      .clk       (clk),
      .res       (res),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rd    (req_rd),
      .req_data  (req_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .stall     (stall),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .sb_busy   (sb_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      int i;
      for (int k = 0; k < 3; k++) begin
`ifdef WB_RR_EN
         i = (mptr + k) % 3;
`else
         i = k;
`endif
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic model_stall();
      logic s;
      s = 1'b0;
      if (rs1 != 0 && (mbusy[rs1] || mwa == rs1)) s = 1'b1;
      if (rs2 != 0 && (mbusy[rs2] || mwa == rs2)) s = 1'b1;
      return s;
   endfunction

   task automatic setreq(input int i, input logic [4:0] rd, input logic [31:0] d);
      req_valid[i]        = 1'b1;
      req_rd[i*5 +: 5]    = rd;
      req_data[i*32 +: 32] = d;
   endtask

   // Starts just after a falling edge, ends at the next falling edge.
   task automatic cycle();
      logic [2:0] exp_rdy;
      logic [4:0] rd;
      #1;
      mgnt    = pick();
      exp_rdy = (mgnt < 0) ? 3'b000 : 3'(1 << mgnt);
      obs_rdy = req_ready;
      chk("req_ready", {29'd0, req_ready}, {29'd0, exp_rdy});
      chk("stall", {31'd0, stall}, {31'd0, model_stall()});
      @(posedge clk);
      if (mgnt >= 0) begin
         rd  = req_rd[mgnt*5 +: 5];
         mwa = rd;
         mwd = req_data[mgnt*32 +: 32];
         if (rd != 0) mbusy[rd] = 1'b0;
         mptr = (mgnt + 1) % 3;
      end else begin
         mwa = 5'd0;
      end
      if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
      @(negedge clk);
      chk("wr_addr", {27'd0, wr_addr}, {27'd0, mwa});
      chk("wr_data", wr_data, mwd);
      chk("sb_busy", sb_busy, mbusy);
   endtask

   task automatic do_reset();
      res = 1'b0;
      #1;
      chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_sb_busy", sb_busy, 32'd0);
      chk("rst_req_ready", {29'd0, req_ready}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      mbusy = '0; mptr = 0; mwa = '0; mwd = '0;
      @(negedge clk);
      res = 1'b1;
   endtask

   initial begin
      req_valid = '0; req_rd = '0; req_data = '0;
      iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
      mbusy = '0; mptr = 0; mwa = '0; mwd = '0; mgnt = -1;
      do_reset();

      // reset then idle
      repeat (3) cycle();

      // issue rd 5, ALU writes it back, rs1 = 5 watches the stall
      iss_valid = 1'b1; iss_rd = 5'd5;
      cycle();
      iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd5;
      cycle();
      chk("s2_busy5_set", {31'd0, sb_busy[5]}, 32'd1);
      setreq(0, 5'd5, 32'hDEAD_BEEF);
      cycle();
      req_valid = '0;
      chk("s2_wr_addr", {27'd0, wr_addr}, 32'd5);
      chk("s2_wr_data", wr_data, 32'hDEAD_BEEF);
      chk("s2_busy5_clr", {31'd0, sb_busy[5]}, 32'd0);
      chk("s2_stall_hold", {31'd0, stall}, 32'd1);
      cycle();
      chk("s2_stall_gone", {31'd0, stall}, 32'd0);
      rs1 = 5'd0;

      // all three requesters valid for six cycles from a fresh pointer
      do_reset();
      for (int i = 0; i < 3; i++) setreq(i, 5'(10 + i), 32'h100 + i);
      for (int s = 0; s < 6; s++) begin
         int e;
`ifdef WB_RR_EN
         e = s % 3;
`else
         e = 0;
`endif
         cycle();
         chk("grant_seq", {29'd0, obs_rdy}, 32'(1 << e));
      end
      req_valid = '0;
      cycle();

      // same-cycle issue and LSU write-back of rd 7: set wins
      iss_valid = 1'b1; iss_rd = 5'd7;
      setreq(1, 5'd7, 32'h7777_0000);
      cycle();
      req_valid = '0; iss_valid = 1'b0; iss_rd = 5'd0;
      chk("s4_busy7", {31'd0, sb_busy[7]}, 32'd1);
      setreq(1, 5'd7, 32'h7777_0001);
      cycle();
      req_valid = '0;

      // rd 0 on both sides
      iss_valid = 1'b1; iss_rd = 5'd0;
      setreq(0, 5'd0, 32'h0000_1234);
      cycle();
      req_valid = '0; iss_valid = 1'b0;
      chk("s5_ready0", {29'd0, obs_rdy}, 32'd1);
      chk("s5_sb_busy", sb_busy, 32'd0);
      chk("s5_wr_addr", {27'd0, wr_addr}, 32'd0);

      // mid-operation reset with pending bits and a write in the output register
      for (int r = 4; r < 8; r++) begin
         iss_valid = 1'b1; iss_rd = 5'(r);
         cycle();
      end
      iss_valid = 1'b0; iss_rd = 5'd0;
      setreq(2, 5'd9, 32'hCAFE_F00D);
      cycle();
      chk("s6_busy_f0", sb_busy, 32'h0000_00F0);
      chk("s6_wr_addr", {27'd0, wr_addr}, 32'd9);
      req_valid = 3'b111; rs1 = 5'd4; rs2 = 5'd9;
      do_reset();
      cycle();
      chk("post_rst_grant0", {29'd0, obs_rdy}, 32'd1);
      req_valid = '0; rs1 = '0; rs2 = '0;

      // random traffic; requesters hold their payload until accepted
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++)
            if (!req_valid[i] && $urandom_range(0, 1) == 1)
               setreq(i, 5'($urandom), $urandom);
         iss_valid = 1'($urandom_range(0, 1));
         iss_rd    = 5'($urandom);
         rs1       = 5'($urandom);
         rs2       = 5'($urandom);
         cycle();
         if (mgnt >= 0) req_valid[mgnt] = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
